// File: rtl/rename_alloc_pkg.sv
// Shared widths, depths and types for the register-rename allocator.
// Free-list depth is the physical registers left over once every architectural register is mapped.
package rename_alloc_pkg;
    localparam int ARCH_WIDTH      = 5;
    localparam int PREG_WIDTH      = 6;
    localparam int FREE_LIST_WIDTH = 4;
    localparam int NUM_ARCH        = 1 << ARCH_WIDTH;
    localparam int AL_DEPTH        = 1 << FREE_LIST_WIDTH;
    localparam int FL_DEPTH        = (1 << PREG_WIDTH) - NUM_ARCH;
    localparam int AL_CNT_WIDTH    = FREE_LIST_WIDTH + 1;

    typedef logic [ARCH_WIDTH-1:0]      arch_t;
    typedef logic [PREG_WIDTH-1:0]      preg_t;
    typedef logic [FREE_LIST_WIDTH-1:0] al_idx_t;
    typedef logic [AL_CNT_WIDTH-1:0]    al_cnt_t;

    typedef struct packed {
        arch_t arch;
        preg_t new_phys;
        preg_t old_phys;
    } al_entry_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;
endpackage

// File: rtl/rename_alloc_if.sv
// Decode/commit/flush bundle for the rename allocator.
// The slave modport is the allocator side; master is the decode/commit side.
interface rename_alloc_if;
    import rename_alloc_pkg::*;

    arch_t   rs_arch;
    arch_t   rt_arch;
    preg_t   rs_phys;
    preg_t   rt_phys;
    logic    alloc_req;
    arch_t   alloc_arch;
    logic    alloc_grant;
    preg_t   alloc_phys;
    preg_t   alloc_old_phys;
    al_idx_t alloc_index;
    logic    commit_valid;
    logic    flush_valid;
    al_idx_t flush_tail;
    logic    busy;
    preg_t   fl_count;

    modport master (
        output rs_arch, rt_arch, alloc_req, alloc_arch, commit_valid, flush_valid, flush_tail,
        input  rs_phys, rt_phys, alloc_grant, alloc_phys, alloc_old_phys, alloc_index, busy, fl_count
    );

    modport slave (
        input  rs_arch, rt_arch, alloc_req, alloc_arch, commit_valid, flush_valid, flush_tail,
        output rs_phys, rt_phys, alloc_grant, alloc_phys, alloc_old_phys, alloc_index, busy, fl_count
    );
endinterface

// File: rtl/rename_alloc_free_fifo.sv
// Circular free list: pop at the front, push at the back, and push at the front (head rewind).
// Resets full, holding BASE..BASE+DEPTH-1 with BASE at the head.
module rename_alloc_free_fifo
    import rename_alloc_pkg::*;
#(
    parameter int DEPTH = FL_DEPTH,
    parameter int BASE  = NUM_ARCH,
    parameter int DW    = PREG_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_pop,
    input  logic          i_push_back,
    input  logic [DW-1:0] i_back_data,
    input  logic          i_push_front,
    input  logic [DW-1:0] i_front_data,
    output logic [DW-1:0] o_front,
    output logic [DW-1:0] o_count
);
    localparam int IW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [IW-1:0] r_head;
    logic [IW-1:0] r_tail;
    logic [DW-1:0] r_count;
    logic [IW-1:0] w_head_dec;

    assign w_head_dec = r_head - 1'b1;
    assign o_front    = r_mem[r_head];
    assign o_count    = r_count;

    // Pop and push-front never coincide (allocation only happens outside rollback).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= DW'(DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DW'(BASE + i);
            end
        end else begin
            if (i_push_back) begin
                r_mem[r_tail] <= i_back_data;
                r_tail        <= r_tail + 1'b1;
            end
            if (i_push_front) begin
                r_mem[w_head_dec] <= i_front_data;
                r_head            <= w_head_dec;
            end else if (i_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + DW'(i_push_back) + DW'(i_push_front) - DW'(i_pop);
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst) r_count <= DW'(DEPTH));
endmodule

// File: rtl/rename_alloc.sv
// Rename allocator: arch->phys map, active list and free list, with one-entry-per-cycle
// rollback of the active list on flush to restore the map and free-list order.
module rename_alloc
    import rename_alloc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    rename_alloc_if.slave bus
);
    state_t        r_state;
    state_t        w_state_next;
    preg_t         r_map [NUM_ARCH];
    al_entry_t     r_al  [AL_DEPTH];
    al_idx_t       r_al_head;
    al_idx_t       r_al_tail;
    al_idx_t       r_target;
    al_idx_t       w_target_next;
    al_cnt_t       r_al_count;
    al_idx_t       w_tail_dec;
    al_entry_t     w_rec_entry;
    preg_t         w_fl_front;
    preg_t         w_fl_count;
    preg_t         w_map_data;
    logic [NUM_ARCH-1:0] w_map_we;
    logic          w_arch_nz;
    logic          w_grant;
    logic          w_alloc_do;
    logic          w_commit;
    logic          w_rec_step;

    assign w_tail_dec  = r_al_tail - 1'b1;
    assign w_rec_entry = r_al[w_tail_dec];
    assign w_arch_nz   = (bus.alloc_arch != '0);

    // Grant looks only at pre-edge occupancy; a same-cycle commit cannot make room.
    assign w_grant    = bus.alloc_req && !bus.flush_valid && (r_state == ST_IDLE)
                        && (w_fl_count != '0) && (r_al_count != al_cnt_t'(AL_DEPTH));
    assign w_alloc_do = w_grant && w_arch_nz;
    assign w_commit   = bus.commit_valid && (r_al_count != '0);

    assign bus.rs_phys        = r_map[bus.rs_arch];
    assign bus.rt_phys        = r_map[bus.rt_arch];
    assign bus.alloc_grant    = w_grant;
    assign bus.alloc_phys     = w_arch_nz ? w_fl_front : '0;
    assign bus.alloc_old_phys = w_arch_nz ? r_map[bus.alloc_arch] : '0;
    assign bus.alloc_index    = r_al_tail;
    assign bus.busy           = (r_state == ST_RECOVER);
    assign bus.fl_count       = w_fl_count;

    always_comb begin
        w_state_next  = r_state;
        w_target_next = r_target;
        w_rec_step    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.flush_valid && (bus.flush_tail != r_al_tail)) begin
                    w_state_next  = ST_RECOVER;
                    w_target_next = bus.flush_tail;
                end
            end
            ST_RECOVER: begin
                if (bus.flush_valid) begin
                    w_target_next = bus.flush_tail;
                end
                w_rec_step = (w_target_next != r_al_tail);
                if (!w_rec_step || (w_tail_dec == w_target_next)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Allocation and rollback are mutually exclusive, so one write port per map entry suffices.
    assign w_map_data = w_rec_step ? w_rec_entry.old_phys : w_fl_front;
    for (genvar gi = 0; gi < NUM_ARCH; gi++) begin : g_map_we
        assign w_map_we[gi] = (w_alloc_do && (bus.alloc_arch == arch_t'(gi)))
                           || (w_rec_step && (w_rec_entry.arch == arch_t'(gi)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_target   <= '0;
            r_al_head  <= '0;
            r_al_tail  <= '0;
            r_al_count <= '0;
            for (int i = 0; i < NUM_ARCH; i++) begin
                r_map[i] <= preg_t'(i);
            end
        end else begin
            r_state  <= w_state_next;
            r_target <= w_target_next;
            for (int i = 0; i < NUM_ARCH; i++) begin
                if (w_map_we[i]) begin
                    r_map[i] <= w_map_data;
                end
            end
            if (w_alloc_do) begin
                r_al_tail <= r_al_tail + 1'b1;
            end else if (w_rec_step) begin
                r_al_tail <= w_tail_dec;
            end
            if (w_commit) begin
                r_al_head <= r_al_head + 1'b1;
            end
            r_al_count <= r_al_count + al_cnt_t'(w_alloc_do) - al_cnt_t'(w_commit)
                          - al_cnt_t'(w_rec_step);
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc_do) begin
            r_al[r_al_tail] <= '{arch: bus.alloc_arch, new_phys: w_fl_front,
                                 old_phys: r_map[bus.alloc_arch]};
        end
    end

    rename_alloc_free_fifo #(
        .DEPTH (FL_DEPTH),
        .BASE  (NUM_ARCH),
        .DW    (PREG_WIDTH)
    ) u_free_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_pop        (w_alloc_do),
        .i_push_back  (w_commit),
        .i_back_data  (r_al[r_al_head].old_phys),
        .i_push_front (w_rec_step),
        .i_front_data (w_rec_entry.new_phys),
        .o_front      (w_fl_front),
        .o_count      (w_fl_count)
    );
endmodule

// File: tb/tb_rename_alloc.sv
// Directed bench for rename_alloc: allocation, full active list, commit recycling,
// flush rollback, arch-0 destinations and reset during rollback.
module tb_rename_alloc;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    rename_alloc_if u_if ();

    rename_alloc u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        u_if.rs_arch      = '0;
        u_if.rt_arch      = '0;
        u_if.alloc_req    = 1'b0;
        u_if.alloc_arch   = '0;
        u_if.commit_valid = 1'b0;
        u_if.flush_valid  = 1'b0;
        u_if.flush_tail   = '0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Drive one allocation, check its combinational results, then clock it in.
    task automatic alloc(input int arch, input int exp_phys, input int exp_idx);
        u_if.alloc_req  = 1'b1;
        u_if.alloc_arch = 5'(arch);
        #1;
        chk("alloc_grant", int'(u_if.alloc_grant), 1);
        chk("alloc_phys", int'(u_if.alloc_phys), exp_phys);
        chk("alloc_index", int'(u_if.alloc_index), exp_idx);
        tick();
        u_if.alloc_req = 1'b0;
        $display("alloc arch=%0d phys=%0d idx=%0d", arch, exp_phys, exp_idx);
    endtask

    task automatic map_chk(input int arch, input int exp);
        u_if.rs_arch = 5'(arch);
        u_if.rt_arch = 5'(arch);
        #1;
        chk("rs_phys", int'(u_if.rs_phys), exp);
        chk("rt_phys", int'(u_if.rt_phys), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        n_chk = 0;
        n_err = 0;

        // Test 1: reset state and back-to-back allocation of the same arch register
        do_reset();
        u_if.alloc_arch = 5'd3;
        #1;
        chk("rst_fl_count", int'(u_if.fl_count), 32);
        chk("rst_busy", int'(u_if.busy), 0);
        chk("rst_alloc_phys", int'(u_if.alloc_phys), 32);
        chk("rst_alloc_index", int'(u_if.alloc_index), 0);
        map_chk(5, 5);
        u_if.rs_arch    = 5'd3;
        u_if.alloc_req  = 1'b1;
        #1;
        chk("t1_old0", int'(u_if.alloc_old_phys), 3);
        chk("t1_rs_pre", int'(u_if.rs_phys), 3);
        alloc(3, 32, 0);
        u_if.alloc_arch = 5'd3;
        #1;
        chk("t1_old1", int'(u_if.alloc_old_phys), 32);
        alloc(3, 33, 1);
        map_chk(3, 33);
        chk("t1_fl_count", int'(u_if.fl_count), 30);

        // Test 3: commit both, then drain the free list to see the recycled order
        u_if.commit_valid = 1'b1;
        tick();
        tick();
        u_if.commit_valid = 1'b0;
        #1;
        chk("t3_fl_count", int'(u_if.fl_count), 32);
        for (int k = 0; k < 32; k++) begin
            u_if.commit_valid = (k > 0);
            alloc(7, (k < 30) ? 34 + k : ((k == 30) ? 3 : 32), (2 + k) % 16);
        end
        u_if.commit_valid = 1'b0;
        #1;
        chk("t3_fl_count_end", int'(u_if.fl_count), 31);

        // Test 2: fill the active list, then commit and request in the same cycle
        do_reset();
        for (int k = 0; k < 16; k++) begin
            alloc(k + 1, 32 + k, k);
        end
        u_if.alloc_req  = 1'b1;
        u_if.alloc_arch = 5'd9;
        #1;
        chk("t2_full_grant", int'(u_if.alloc_grant), 0);
        chk("t2_full_index", int'(u_if.alloc_index), 0);
        chk("t2_full_fl", int'(u_if.fl_count), 16);
        u_if.commit_valid = 1'b1;
        #1;
        chk("t2_commit_grant", int'(u_if.alloc_grant), 0);
        tick();
        u_if.commit_valid = 1'b0;
        #1;
        chk("t2_after_commit_fl", int'(u_if.fl_count), 17);
        chk("t2_next_grant", int'(u_if.alloc_grant), 1);
        chk("t2_next_phys", int'(u_if.alloc_phys), 48);
        tick();
        u_if.alloc_req = 1'b0;
        #1;
        chk("t2_final_fl", int'(u_if.fl_count), 16);

        // Test 4: allocate arch 1..5, flush back to tail 2
        do_reset();
        for (int k = 0; k < 5; k++) begin
            alloc(k + 1, 32 + k, k);
        end
        u_if.flush_valid = 1'b1;
        u_if.flush_tail  = 4'd2;
        #1;
        chk("t4_busy_pre", int'(u_if.busy), 0);
        tick();
        u_if.flush_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && u_if.busy; i++) begin
            n++;
            tick();
        end
        chk("t4_busy_cycles", n, 3);
        $display("flush tail=2 busy_cycles=%0d", n);
        map_chk(3, 3);
        map_chk(4, 4);
        map_chk(5, 5);
        map_chk(1, 32);
        map_chk(2, 33);
        chk("t4_fl_count", int'(u_if.fl_count), 30);
        u_if.alloc_arch = 5'd6;
        #1;
        chk("t4_next_phys", int'(u_if.alloc_phys), 34);
        chk("t4_next_index", int'(u_if.alloc_index), 2);

        // Test 5: arch 0 destination, then flush blocking a grant
        u_if.alloc_req  = 1'b1;
        u_if.alloc_arch = 5'd0;
        #1;
        chk("t5_a0_grant", int'(u_if.alloc_grant), 1);
        chk("t5_a0_phys", int'(u_if.alloc_phys), 0);
        chk("t5_a0_old", int'(u_if.alloc_old_phys), 0);
        tick();
        $display("alloc arch=0 phys=0 (no state change)");
        chk("t5_a0_fl", int'(u_if.fl_count), 30);
        chk("t5_a0_index", int'(u_if.alloc_index), 2);
        u_if.alloc_arch  = 5'd6;
        u_if.flush_valid = 1'b1;
        u_if.flush_tail  = 4'd2;
        #1;
        chk("t5_flush_grant", int'(u_if.alloc_grant), 0);
        tick();
        idle_in();
        #1;
        chk("t5_flush_busy", int'(u_if.busy), 0);
        chk("t5_flush_fl", int'(u_if.fl_count), 30);

        // Test 6: reset arriving in the second cycle of a rollback
        do_reset();
        for (int k = 0; k < 5; k++) begin
            alloc(k + 1, 32 + k, k);
        end
        u_if.flush_valid = 1'b1;
        u_if.flush_tail  = 4'd0;
        tick();
        u_if.flush_valid = 1'b0;
        #1;
        chk("t6_busy_rec", int'(u_if.busy), 1);
        tick();
        rst = 1'b1;
        u_if.alloc_arch = 5'd1;
        #1;
        chk("t6_busy", int'(u_if.busy), 0);
        chk("t6_fl_count", int'(u_if.fl_count), 32);
        chk("t6_alloc_phys", int'(u_if.alloc_phys), 32);
        chk("t6_alloc_index", int'(u_if.alloc_index), 0);
        for (int a = 1; a <= 5; a++) begin
            map_chk(a, a);
        end
        $display("reset mid-recover: map identity restored");
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
